matrix_frame_scan: RTL and testbench
====================================

Name: matrix_frame_scan

Overview:
- Upstream feeder for the 16x8 LED dot-matrix column multiplexer.
- Holds a double-buffered 16-column x 8-row frame: a front bank is displayed while a back bank is written.
- Presents the front bank as Col00..Col15 and generates the rotating 4-bit Col_Select plus a one-hot column enable.
- Swaps banks only at frame boundaries, so the elevator display never tears mid-frame.

Parameters:
- DIV, 5000, clock cycles each column is held (dwell); legal range 2..65535.
- BLANK, 2, cycles at the start of each dwell with all column enables off; must be < DIV. Used only with MATRIX_SCAN_BLANK_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write strobe into the back bank
- wr_addr  input  4  back-bank column index, 0..15
- wr_data  input  8  column pixel byte; bit0 = top row
- swap_req  input  1  one-cycle pulse requesting a bank swap at the next frame boundary
- Col_Select  output  4  current column index, to the column mux
- Col_En  output  16  one-hot column drive, active-high
- Col00..Col15  output  8 each  front-bank column bytes
- swap_pending  output  1  swap requested but not yet taken
- frame_tick  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - cnt=0, Col_Select=0, bank_sel=0.
  - Both banks cleared to 8'h00.
  - swap_pending=0, frame_tick=0.
  - Col_En=16'h0001 without blanking; 16'h0000 with blanking.
  - rst mid-frame or mid-pending-swap discards everything, including a pending swap.
- Dwell counter:
  - cnt counts 0..DIV-1, then wraps to 0.
  - On the wrap, Col_Select increments; 15 wraps to 0.
- Column enable:
  - Col_En is registered.
  - Col_En = 1<<Col_Select and changes on the same edge as Col_Select.
- Frame boundary:
  - Defined as the edge where cnt==DIV-1 and Col_Select==15.
  - On the next cycle, Col_Select==0 and frame_tick==1 for exactly one cycle.
- Banks:
  - bank_sel selects the front bank; the back bank is !bank_sel.
  - Col00..Col15 are continuous reads of the front bank, no latency.
- Writes:
  - wr_en=1 writes wr_data into back[wr_addr] at the edge.
  - The front bank is never writable.
  - Back-to-back writes are allowed every cycle; a repeated address means last write wins.
- Swap:
  - swap_req sets swap_pending.
  - At a frame boundary with swap_pending=1 or swap_req=1: bank_sel toggles and swap_pending clears on the same edge.
  - New content therefore appears starting at column 0 of the next frame.
  - A swap_req arriving exactly on the boundary edge is honoured at that boundary.
  - Repeated swap_req while pending has no additional effect; one swap results.
- Simultaneous write and swap on the boundary edge: the write lands in the pre-swap back bank, so it is visible in the new front frame.
- After a swap, the old front becomes the back bank unchanged. The writer must overwrite the columns it wants to change; no automatic copy.
- Frame period = 16*DIV cycles.
- No other latency; all outputs except Col00..Col15 are registered.

Optional Feature:
- Macro MATRIX_SCAN_BLANK_EN, when defined:
  - Col_En=16'h0000 while cnt<BLANK.
  - Col_En = 1<<Col_Select for cnt>=BLANK.
  - Suppresses ghosting from row data settling.
- When undefined:
  - No blanking logic is built; the BLANK parameter is ignored.
  - Col_En is active for the whole dwell.
- Col_Select, frame_tick and swap timing are identical either way.

Test Plan:
- Reset and scan, DIV=4, macro off: hold rst 3 cycles then release.
  - Col_Select steps 0,1,..,15,0 every 4 cycles.
  - Col_En tracks as 0001, 0002, ... 8000.
  - frame_tick pulses once per 64 cycles, coincident with Col_Select returning to 0.
- Back-bank isolation: write addr 5 <- 8'hA5 with no swap.
  - Col05 stays 8'h00 for 3 full frames.
- Swap: write addr 0 <- 8'h3C, then pulse swap_req mid-frame.
  - swap_pending=1 until the boundary.
  - Next cycle after the boundary: Col00=8'h3C, swap_pending=0.
- Boundary race, on the boundary edge:
  - Assert swap_req together with wr_en, addr 15 <- 8'hFF.
  - Required: swap taken, Col15=8'hFF in the new frame, frame_tick=1.
- Reset mid-pending: pulse swap_req, then assert rst before the boundary.
  - After release: swap_pending=0, all ColNN=8'h00, Col_Select=0.
- Blanking, macro on, DIV=4, BLANK=1:
  - For each column, Col_En=0 for 1 cycle, then one-hot for 3 cycles.
  - Col_Select timing is unchanged from the macro-off run.

Source files
------------

// File: rtl/matrix_frame_scan_if.sv
// Bus bundle for matrix_frame_scan: back-bank write port, swap request,
// and the column-scan outputs toward the LED column multiplexer.
//   master : writer / observer side (drives writes and swap_req)
//   slave  : matrix_frame_scan side (drives scan, column data and status)
interface matrix_frame_scan_if;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        swap_req;
  logic [3:0]  Col_Select;
  logic [15:0] Col_En;
  logic [7:0]  Col00, Col01, Col02, Col03, Col04, Col05, Col06, Col07;
  logic [7:0]  Col08, Col09, Col10, Col11, Col12, Col13, Col14, Col15;
  logic        swap_pending;
  logic        frame_tick;

  modport master (
    output wr_en, wr_addr, wr_data, swap_req,
    input  Col_Select, Col_En, swap_pending, frame_tick,
    input  Col00, Col01, Col02, Col03, Col04, Col05, Col06, Col07,
    input  Col08, Col09, Col10, Col11, Col12, Col13, Col14, Col15
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, swap_req,
    output Col_Select, Col_En, swap_pending, frame_tick,
    output Col00, Col01, Col02, Col03, Col04, Col05, Col06, Col07,
    output Col08, Col09, Col10, Col11, Col12, Col13, Col14, Col15
  );
endinterface

// File: rtl/matrix_frame_scan.sv
// Double-buffered 16x8 dot-matrix frame store with column scan generator.
// The front bank is shown on Col00..Col15 while the back bank is written;
// banks swap only at a frame boundary so a frame never tears.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : matrix_frame_scan_if.slave (writes, swap_req, scan outputs)
// Parameters: DIV (dwell cycles per column, 2..65535), BLANK (blank cycles
// at start of dwell, < DIV).
// Optional feature: define MATRIX_SCAN_BLANK_EN to blank Col_En while cnt<BLANK.
module matrix_frame_scan #(
  parameter int unsigned DIV   = 5000,
  parameter int unsigned BLANK = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  matrix_frame_scan_if.slave   bus
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned NCOL  = 16;
`ifdef MATRIX_SCAN_BLANK_EN
  localparam logic [15:0] RST_EN = 16'h0000;
`else
  localparam logic [15:0] RST_EN = 16'h0001;
`endif

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       col_sel, col_sel_nxt;
  logic [15:0]      col_en, col_en_nxt;
  logic             dwell_end, frame_end, take_swap;
  logic             bank_sel, swap_pending, frame_tick;
  logic [7:0]       bank0 [NCOL];
  logic [7:0]       bank1 [NCOL];
  logic [7:0]       front [NCOL];

  // Next-state for dwell counter, column index, column enable and swap decision.
  always_comb begin
    dwell_end   = (cnt == CNT_W'(DIV - 1));
    frame_end   = dwell_end && (col_sel == 4'd15);
    take_swap   = frame_end && (swap_pending || bus.swap_req);
    cnt_nxt     = dwell_end ? '0 : cnt + CNT_W'(1);
    col_sel_nxt = dwell_end ? col_sel + 4'd1 : col_sel;
`ifdef MATRIX_SCAN_BLANK_EN
    col_en_nxt  = (32'(cnt_nxt) < BLANK) ? 16'h0000 : (16'd1 << col_sel_nxt);
`else
    col_en_nxt  = 16'd1 << col_sel_nxt;
`endif
  end

`ifndef MATRIX_SCAN_BLANK_EN
  // BLANK has no effect without blanking; fold it into a sink signal.
  logic unused_blank;
  assign unused_blank = ^32'(BLANK);
`endif

  // State registers. Writes use the pre-swap bank_sel, so a write on the
  // boundary edge lands in the bank that becomes front on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      col_sel      <= '0;
      col_en       <= RST_EN;
      bank_sel     <= 1'b0;
      swap_pending <= 1'b0;
      frame_tick   <= 1'b0;
      for (int i = 0; i < NCOL; i++) begin
        bank0[i] <= 8'h00;
        bank1[i] <= 8'h00;
      end
    end else begin
      cnt        <= cnt_nxt;
      col_sel    <= col_sel_nxt;
      col_en     <= col_en_nxt;
      frame_tick <= frame_end;
      if (take_swap) begin
        bank_sel     <= ~bank_sel;
        swap_pending <= 1'b0;
      end else if (bus.swap_req) begin
        swap_pending <= 1'b1;
      end
      if (bus.wr_en) begin
        if (bank_sel) bank0[bus.wr_addr] <= bus.wr_data;
        else          bank1[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // Front-bank read mux, no latency.
  always_comb begin
    for (int i = 0; i < NCOL; i++) begin
      front[i] = bank_sel ? bank1[i] : bank0[i];
    end
  end

  assign bus.Col_Select   = col_sel;
  assign bus.Col_En       = col_en;
  assign bus.swap_pending = swap_pending;
  assign bus.frame_tick   = frame_tick;
  assign bus.Col00 = front[0];
  assign bus.Col01 = front[1];
  assign bus.Col02 = front[2];
  assign bus.Col03 = front[3];
  assign bus.Col04 = front[4];
  assign bus.Col05 = front[5];
  assign bus.Col06 = front[6];
  assign bus.Col07 = front[7];
  assign bus.Col08 = front[8];
  assign bus.Col09 = front[9];
  assign bus.Col10 = front[10];
  assign bus.Col11 = front[11];
  assign bus.Col12 = front[12];
  assign bus.Col13 = front[13];
  assign bus.Col14 = front[14];
  assign bus.Col15 = front[15];

endmodule

// File: tb/tb_matrix_frame_scan.sv
// Directed bench for matrix_frame_scan with DIV=4, BLANK=1 (frame = 64 cycles).
// Expected Col_En follows MATRIX_SCAN_BLANK_EN if it is defined for the build.
module tb_matrix_frame_scan;

  logic clk;
  logic rst;
  matrix_frame_scan_if bus ();

  matrix_frame_scan #(.DIV(4), .BLANK(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] cols [16];
  assign cols[0]  = bus.Col00;
  assign cols[1]  = bus.Col01;
  assign cols[2]  = bus.Col02;
  assign cols[3]  = bus.Col03;
  assign cols[4]  = bus.Col04;
  assign cols[5]  = bus.Col05;
  assign cols[6]  = bus.Col06;
  assign cols[7]  = bus.Col07;
  assign cols[8]  = bus.Col08;
  assign cols[9]  = bus.Col09;
  assign cols[10] = bus.Col10;
  assign cols[11] = bus.Col11;
  assign cols[12] = bus.Col12;
  assign cols[13] = bus.Col13;
  assign cols[14] = bus.Col14;
  assign cols[15] = bus.Col15;

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;   // edges since reset release

  typedef struct {
    int          n;
    logic [3:0]  sel;
    logic [15:0] en;
    logic        first;  // first cycle of a dwell (blanked when enabled)
    logic        tick;
  } vec_t;

  vec_t tbl [6];

`ifdef MATRIX_SCAN_BLANK_EN
  localparam logic [15:0] RST_EN = 16'h0000;
`else
  localparam logic [15:0] RST_EN = 16'h0001;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at n=%0d: got %h, required %h", name, n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to_phase(input int ph);
    for (int k = 0; k < 64 && (n % 64) != ph; k++) step();
  endtask

  function automatic logic [15:0] exp_en(input logic [15:0] onehot, input logic first);
`ifdef MATRIX_SCAN_BLANK_EN
    return first ? 16'h0000 : onehot;
`else
    return (first === 1'bx) ? 16'hxxxx : onehot;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{n: 64,  sel: 4'd0,  en: 16'h0001, first: 1'b1, tick: 1'b1};
    tbl[1] = '{n: 65,  sel: 4'd0,  en: 16'h0001, first: 1'b0, tick: 1'b0};
    tbl[2] = '{n: 68,  sel: 4'd1,  en: 16'h0002, first: 1'b1, tick: 1'b0};
    tbl[3] = '{n: 127, sel: 4'd15, en: 16'h8000, first: 1'b0, tick: 1'b0};
    tbl[4] = '{n: 128, sel: 4'd0,  en: 16'h0001, first: 1'b1, tick: 1'b1};
    tbl[5] = '{n: 129, sel: 4'd0,  en: 16'h0001, first: 1'b0, tick: 1'b0};

    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 8'h00; bus.swap_req = 1'b0;

    // Reset held for three edges.
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_sel", 32'(bus.Col_Select), 32'd0);
    chk("rst_en", 32'(bus.Col_En), 32'(RST_EN));
    chk("rst_pending", 32'(bus.swap_pending), 32'd0);
    chk("rst_tick", 32'(bus.frame_tick), 32'd0);
    for (int i = 0; i < 16; i++) chk("rst_col", 32'(cols[i]), 32'd0);
    rst = 1'b0;
    n = 0;

    // First frame, every cycle: column steps every 4 cycles.
    for (int i = 0; i < 64; i++) begin
      chk("scan_sel", 32'(bus.Col_Select), 32'((i / 4) % 16));
      chk("scan_en", 32'(bus.Col_En), 32'(exp_en(16'd1 << ((i / 4) % 16), (i % 4) == 0)));
      chk("scan_tick", 32'(bus.frame_tick), 32'd0);
      step();
    end

    // Table of frame-boundary points.
    for (int v = 0; v < 6; v++) begin
      while (n < tbl[v].n) step();
      chk("tbl_sel", 32'(bus.Col_Select), 32'(tbl[v].sel));
      chk("tbl_en", 32'(bus.Col_En), 32'(exp_en(tbl[v].en, tbl[v].first)));
      chk("tbl_tick", 32'(bus.frame_tick), 32'(tbl[v].tick));
    end

    // Back-bank isolation: write without swap, front stays clear.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 8'hA5;
    step();
    bus.wr_en = 1'b0;
    for (int f = 0; f < 3; f++) begin
      repeat (64) step();
      chk("iso_col05", 32'(bus.Col05), 32'h00);
    end
    chk("iso_pending", 32'(bus.swap_pending), 32'd0);

    // Swap requested mid-frame, taken at the boundary.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 8'h3C;
    step();
    bus.wr_en = 1'b0;
    run_to_phase(20);
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    chk("swap_pending_set", 32'(bus.swap_pending), 32'd1);
    run_to_phase(63);
    chk("swap_pending_hold", 32'(bus.swap_pending), 32'd1);
    chk("swap_col00_old", 32'(bus.Col00), 32'h00);
    step();
    chk("swap_col00_new", 32'(bus.Col00), 32'h3C);
    chk("swap_col05_new", 32'(bus.Col05), 32'hA5);
    chk("swap_pending_clr", 32'(bus.swap_pending), 32'd0);
    chk("swap_tick", 32'(bus.frame_tick), 32'd1);
    chk("swap_sel", 32'(bus.Col_Select), 32'd0);

    // Boundary race: swap_req and write on the boundary edge itself.
    run_to_phase(63);
    bus.swap_req = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd15; bus.wr_data = 8'hFF;
    step();
    bus.swap_req = 1'b0; bus.wr_en = 1'b0;
    chk("race_col15", 32'(bus.Col15), 32'hFF);
    chk("race_col00", 32'(bus.Col00), 32'h00);
    chk("race_tick", 32'(bus.frame_tick), 32'd1);
    chk("race_pending", 32'(bus.swap_pending), 32'd0);
    chk("race_sel", 32'(bus.Col_Select), 32'd0);

    // Repeated swap_req while pending yields exactly one swap.
    run_to_phase(10);
    for (int r = 0; r < 3; r++) begin
      bus.swap_req = 1'b1;
      step();
      bus.swap_req = 1'b0;
      step();
    end
    chk("rep_pending", 32'(bus.swap_pending), 32'd1);
    run_to_phase(0);
    chk("rep_col00", 32'(bus.Col00), 32'h3C);
    chk("rep_pending_clr", 32'(bus.swap_pending), 32'd0);
    repeat (64) step();
    chk("rep_no_second", 32'(bus.Col00), 32'h3C);
    chk("rep_tick2", 32'(bus.frame_tick), 32'd1);

    // Reset while a swap is pending discards it and clears both banks.
    run_to_phase(30);
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    chk("mid_pending", 32'(bus.swap_pending), 32'd1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n = 0;
    chk("mid_rst_pending", 32'(bus.swap_pending), 32'd0);
    chk("mid_rst_sel", 32'(bus.Col_Select), 32'd0);
    chk("mid_rst_en", 32'(bus.Col_En), 32'(RST_EN));
    chk("mid_rst_tick", 32'(bus.frame_tick), 32'd0);
    for (int i = 0; i < 16; i++) chk("mid_rst_col", 32'(cols[i]), 32'd0);
    repeat (64) step();
    chk("post_rst_tick", 32'(bus.frame_tick), 32'd1);
    chk("post_rst_pending", 32'(bus.swap_pending), 32'd0);
    chk("post_rst_col00", 32'(bus.Col00), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
